insn_legal_chk: RTL and testbench



---
 rtl/insn_legal_chk.sv | 175 +++++++++++++++++
 tb/tb_insn_legal_chk.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/insn_legal_chk.sv
// RV32 instruction-legality checker: one pipeline stage with stall, sticky
// capture of the first illegal instruction and a saturating illegal counter.
module insn_legal_chk #(
  parameter bit          EN_M   = 1'b0,
  parameter bit          EN_SYS = 1'b0,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [31:0]      i_inst,
  input  logic [31:0]      i_pc,
  input  logic             i_inst_vld,
  input  logic             i_stall,
  input  logic             i_clr,
  input  logic             i_cnt_clr,
  output logic             o_insn_vld,
  output logic             o_illegal,
  output logic [31:0]      o_inst,
  output logic [31:0]      o_pc,
  output logic             o_trap_vld,
  output logic [31:0]      o_trap_inst,
  output logic [31:0]      o_trap_pc,
  output logic [CNT_W-1:0] o_illegal_cnt
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Full field check; anything not explicitly accepted is illegal.
  function automatic logic f_legal(input logic [31:0] inst);
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       ok;
    op = inst[6:0];
    f3 = inst[14:12];
    f7 = inst[31:25];
    ok = 1'b0;
    case (op)
      OP_R: begin
        case (f7)
          7'b0000000: ok = 1'b1;
          7'b0100000: ok = (f3 == 3'b000) || (f3 == 3'b101);
          7'b0000001: ok = EN_M;
          default:    ok = 1'b0;
        endcase
      end
      OP_IALU: begin
        case (f3)
          3'b001:  ok = (f7 == 7'b0000000);
          3'b101:  ok = (f7 == 7'b0000000) || (f7 == 7'b0100000);
          default: ok = 1'b1;
        endcase
      end
      OP_LOAD: begin
        case (f3)
          3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ok = 1'b1;
          default:                                ok = 1'b0;
        endcase
      end
      OP_STORE:  ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
      OP_BRANCH: ok = (f3 != 3'b010) && (f3 != 3'b011);
      OP_JALR:   ok = (f3 == 3'b000);
      OP_JAL, OP_LUI, OP_AUIPC: ok = 1'b1;
      OP_FENCE:  ok = EN_SYS && (f3 == 3'b000);
      OP_SYSTEM: begin
        case (f3)
          3'b000: ok = EN_SYS && ((inst == 32'h0000_0073) || (inst == 32'h0010_0073));
          3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111: ok = EN_SYS;
          default: ok = 1'b0;
        endcase
      end
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  logic             w_legal;
  logic             w_load;
  logic             w_ill_load;
  logic             w_cap_load;

  logic             r_insn_vld;
  logic             r_illegal;
  logic [31:0]      r_inst;
  logic [31:0]      r_pc;
  logic             r_trap_vld;
  logic [31:0]      r_trap_inst;
  logic [31:0]      r_trap_pc;
  logic [CNT_W-1:0] r_cnt;

  // Legality and load-event decode for the current input.
  always_comb begin
    w_legal    = f_legal(i_inst);
    w_load     = ~i_stall & i_inst_vld;
    w_ill_load = w_load & ~w_legal;
    w_cap_load = w_ill_load & (~r_trap_vld | i_clr);
  end

  // Stage register: loads on a load event, drops flags on a bubble, holds on stall.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_insn_vld <= 1'b0;
      r_illegal  <= 1'b0;
      r_inst     <= 32'h0000_0000;
      r_pc       <= 32'h0000_0000;
    end else if (!i_stall) begin
      r_insn_vld <= i_inst_vld & w_legal;
      r_illegal  <= i_inst_vld & ~w_legal;
      if (i_inst_vld) begin
        r_inst <= i_inst;
        r_pc   <= i_pc;
      end else begin
        r_inst <= r_inst;
        r_pc   <= r_pc;
      end
    end else begin
      r_insn_vld <= r_insn_vld;
      r_illegal  <= r_illegal;
      r_inst     <= r_inst;
      r_pc       <= r_pc;
    end
  end

  // Trap capture: first illegal wins unless cleared in the same cycle.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_trap_vld  <= 1'b0;
      r_trap_inst <= 32'h0000_0000;
      r_trap_pc   <= 32'h0000_0000;
    end else if (w_cap_load) begin
      r_trap_vld  <= 1'b1;
      r_trap_inst <= i_inst;
      r_trap_pc   <= i_pc;
    end else if (i_clr) begin
      r_trap_vld  <= 1'b0;
    end else begin
      r_trap_vld  <= r_trap_vld;
    end
  end

  // Saturating illegal counter; a clear coinciding with an increment leaves 1.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (i_cnt_clr) begin
      r_cnt <= w_ill_load ? {{(CNT_W-1){1'b0}}, 1'b1} : {CNT_W{1'b0}};
    end else if (w_ill_load && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_insn_vld    = r_insn_vld;
  assign o_illegal     = r_illegal;
  assign o_inst        = r_inst;
  assign o_pc          = r_pc;
  assign o_trap_vld    = r_trap_vld;
  assign o_trap_inst   = r_trap_inst;
  assign o_trap_pc     = r_trap_pc;
  assign o_illegal_cnt = r_cnt;

endmodule

// File: tb/tb_insn_legal_chk.sv
// Directed bench: dut A (no M, no SYSTEM, 16-bit counter) and dut B (M, SYSTEM,
// 2-bit counter) share stimulus; each task checks hand-computed expectations.
module tb_insn_legal_chk;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic [31:0] i_inst = 32'h0;
  logic [31:0] i_pc = 32'h0;
  logic        i_inst_vld = 1'b0;
  logic        i_stall = 1'b0;
  logic        i_clr = 1'b0;
  logic        i_cnt_clr = 1'b0;

  logic        a_vld, a_ill, a_tv, b_vld, b_ill, b_tv;
  logic [31:0] a_inst, a_pc, a_ti, a_tp, b_inst, b_pc, b_ti, b_tp;
  logic [15:0] a_cnt;
  logic [1:0]  b_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 i_clk = ~i_clk;

  insn_legal_chk #(.EN_M(1'b0), .EN_SYS(1'b0), .CNT_W(16)) dut_a (
    .i_clk(i_clk), .i_reset(i_reset), .i_inst(i_inst), .i_pc(i_pc),
    .i_inst_vld(i_inst_vld), .i_stall(i_stall), .i_clr(i_clr), .i_cnt_clr(i_cnt_clr),
    .o_insn_vld(a_vld), .o_illegal(a_ill), .o_inst(a_inst), .o_pc(a_pc),
    .o_trap_vld(a_tv), .o_trap_inst(a_ti), .o_trap_pc(a_tp), .o_illegal_cnt(a_cnt));

  insn_legal_chk #(.EN_M(1'b1), .EN_SYS(1'b1), .CNT_W(2)) dut_b (
    .i_clk(i_clk), .i_reset(i_reset), .i_inst(i_inst), .i_pc(i_pc),
    .i_inst_vld(i_inst_vld), .i_stall(i_stall), .i_clr(i_clr), .i_cnt_clr(i_cnt_clr),
    .o_insn_vld(b_vld), .o_illegal(b_ill), .o_inst(b_inst), .o_pc(b_pc),
    .o_trap_vld(b_tv), .o_trap_inst(b_ti), .o_trap_pc(b_tp), .o_illegal_cnt(b_cnt));

  task automatic drive(input logic [31:0] inst, input logic [31:0] pc, input logic vld,
                       input logic stall, input logic clr, input logic cclr);
    i_inst = inst; i_pc = pc; i_inst_vld = vld; i_stall = stall; i_clr = clr; i_cnt_clr = cclr;
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    i_reset = 1'b0;
    drive(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(); step();
    n_tests++; if ({a_vld, a_ill, a_tv} !== 3'b000) begin n_fail++; $display("FAIL reset_a_flags got=%b exp=000", {a_vld, a_ill, a_tv}); end
    n_tests++; if ({a_inst, a_pc, a_ti, a_tp} !== 128'h0) begin n_fail++; $display("FAIL reset_a_data got=%h exp=0", {a_inst, a_pc, a_ti, a_tp}); end
    n_tests++; if (a_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_a_cnt got=%0d exp=0", a_cnt); end
    n_tests++; if ({b_vld, b_ill, b_tv, b_cnt} !== 5'b0) begin n_fail++; $display("FAIL reset_b got=%b exp=00000", {b_vld, b_ill, b_tv, b_cnt}); end
    i_reset = 1'b1;
  endtask

  task automatic test_add();
    drive(32'h00B5_0533, 32'h0000_0010, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    n_tests++; if ({a_vld, a_ill} !== 2'b10) begin n_fail++; $display("FAIL add_flags got=%b exp=10", {a_vld, a_ill}); end
    n_tests++; if (a_inst !== 32'h00B5_0533 || a_pc !== 32'h10) begin n_fail++; $display("FAIL add_data got=%h/%h exp=00b50533/10", a_inst, a_pc); end
    n_tests++; if (a_cnt !== 16'd0 || a_tv !== 1'b0) begin n_fail++; $display("FAIL add_cnt got=%0d tv=%b exp=0 tv=0", a_cnt, a_tv); end
  endtask

  task automatic test_mul();
    drive(32'h02B5_0533, 32'h0000_0040, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    n_tests++; if ({a_vld, a_ill, a_tv} !== 3'b011) begin n_fail++; $display("FAIL mul_a_flags got=%b exp=011", {a_vld, a_ill, a_tv}); end
    n_tests++; if (a_ti !== 32'h02B5_0533 || a_tp !== 32'h40) begin n_fail++; $display("FAIL mul_a_trap got=%h/%h exp=02b50533/40", a_ti, a_tp); end
    n_tests++; if (a_cnt !== 16'd1) begin n_fail++; $display("FAIL mul_a_cnt got=%0d exp=1", a_cnt); end
    n_tests++; if ({b_vld, b_ill, b_tv, b_cnt} !== 5'b10000) begin n_fail++; $display("FAIL mul_b got=%b exp=10000", {b_vld, b_ill, b_tv, b_cnt}); end
  endtask

  task automatic test_back_to_back();
    drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    n_tests++; if ({a_vld, a_ill, a_tv} !== 3'b000 || a_cnt !== 16'd0) begin n_fail++; $display("FAIL clr_all got=%b cnt=%0d exp=000 cnt=0", {a_vld, a_ill, a_tv}, a_cnt); end
    n_tests++; if (a_ti !== 32'h02B5_0533) begin n_fail++; $display("FAIL clr_keeps_inst got=%h exp=02b50533", a_ti); end
    drive(32'h0005_3503, 32'h0000_0100, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    n_tests++; if ({a_ill, b_ill} !== 2'b11) begin n_fail++; $display("FAIL ld_illegal got=%b exp=11", {a_ill, b_ill}); end
    drive(32'hFFFF_FFFF, 32'h0000_0104, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    n_tests++; if (a_ti !== 32'h0005_3503 || a_tp !== 32'h100 || a_tv !== 1'b1) begin n_fail++; $display("FAIL first_wins got=%h/%h tv=%b exp=00053503/100 tv=1", a_ti, a_tp, a_tv); end
    n_tests++; if (a_cnt !== 16'd2 || b_cnt !== 2'd2) begin n_fail++; $display("FAIL b2b_cnt got=%0d/%0d exp=2/2", a_cnt, b_cnt); end
    // funct7 0100000 with funct3 010 is an illegal R-type
    drive(32'h4000_A0B3, 32'h0000_0108, 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    n_tests++; if (a_ti !== 32'h4000_A0B3 || a_tp !== 32'h108 || a_tv !== 1'b1) begin n_fail++; $display("FAIL clr_recapture got=%h/%h tv=%b exp=4000a0b3/108 tv=1", a_ti, a_tp, a_tv); end
    n_tests++; if (a_cnt !== 16'd3 || b_cnt !== 2'd3) begin n_fail++; $display("FAIL b2b_cnt3 got=%0d/%0d exp=3/3", a_cnt, b_cnt); end
    drive(32'h0000_A0B3, 32'h0000_010C, 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    n_tests++; if ({a_vld, a_ill, a_tv} !== 3'b100 || a_ti !== 32'h4000_A0B3) begin n_fail++; $display("FAIL slt_clr got=%b ti=%h exp=100 ti=4000a0b3", {a_vld, a_ill, a_tv}, a_ti); end
  endtask

  task automatic test_system();
    drive(32'h0000_0073, 32'h0000_0200, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    n_tests++; if ({a_ill, b_vld} !== 2'b11) begin n_fail++; $display("FAIL ecall got=%b exp=11", {a_ill, b_vld}); end
    n_tests++; if (a_tv !== 1'b1 || a_tp !== 32'h200 || a_cnt !== 16'd4) begin n_fail++; $display("FAIL ecall_trap got tv=%b pc=%h cnt=%0d exp 1/200/4", a_tv, a_tp, a_cnt); end
    drive(32'h0000_000F, 32'h0000_0204, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    n_tests++; if ({a_ill, b_vld} !== 2'b11) begin n_fail++; $display("FAIL fence got=%b exp=11", {a_ill, b_vld}); end
    drive(32'h0020_0073, 32'h0000_0208, 1'b1, 1'b0, 1'b0, 1'b1);
    step();
    n_tests++; if ({b_vld, b_ill} !== 2'b01) begin n_fail++; $display("FAIL sys_bad got=%b exp=01", {b_vld, b_ill}); end
    n_tests++; if (a_cnt !== 16'd1 || b_cnt !== 2'd1) begin n_fail++; $display("FAIL cntclr_inc got=%0d/%0d exp=1/1", a_cnt, b_cnt); end
  endtask

  task automatic test_stall();
    drive(32'h4015_5513, 32'h0000_0300, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    n_tests++; if ({a_vld, a_ill} !== 2'b10) begin n_fail++; $display("FAIL srai got=%b exp=10", {a_vld, a_ill}); end
    for (int k = 0; k < 3; k++) begin
      drive(32'hFFFF_FFFF, 32'h0000_0304, 1'b1, 1'b1, 1'b0, 1'b0);
      step();
      n_tests++; if ({a_vld, a_ill} !== 2'b10 || a_inst !== 32'h4015_5513 || a_pc !== 32'h300 || a_cnt !== 16'd1) begin
        n_fail++; $display("FAIL stall_hold[%0d] got=%b %h %h cnt=%0d exp=10 40155513 300 cnt=1", k, {a_vld, a_ill}, a_inst, a_pc, a_cnt); end
    end
    drive(32'hFFFF_FFFF, 32'h0000_0304, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    n_tests++; if ({a_vld, a_ill} !== 2'b00 || a_inst !== 32'h4015_5513) begin n_fail++; $display("FAIL bubble got=%b %h exp=00 40155513", {a_vld, a_ill}, a_inst); end
  endtask

  task automatic test_saturate_reset();
    drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    n_tests++; if (b_cnt !== 2'd0) begin n_fail++; $display("FAIL sat_clr got=%0d exp=0", b_cnt); end
    for (int k = 1; k <= 5; k++) begin
      drive(32'hFFFF_FFFF, 32'h400 + 32'(k), 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      n_tests++; if (b_cnt !== ((k > 3) ? 2'd3 : 2'(k)) || a_cnt !== 16'(k)) begin
        n_fail++; $display("FAIL sat[%0d] got=%0d/%0d exp=%0d/%0d", k, b_cnt, a_cnt, (k > 3) ? 3 : k, k); end
    end
    drive(32'hFFFF_FFFF, 32'h0000_0500, 1'b1, 1'b0, 1'b0, 1'b0);
    #2 i_reset = 1'b0;
    #1;
    n_tests++; if ({a_vld, a_ill, a_tv, a_inst, a_pc, a_ti, a_tp, a_cnt} !== 147'h0) begin n_fail++; $display("FAIL async_rst_a got nonzero vld=%b ill=%b tv=%b cnt=%0d", a_vld, a_ill, a_tv, a_cnt); end
    n_tests++; if ({b_vld, b_ill, b_tv, b_inst, b_pc, b_ti, b_tp, b_cnt} !== 133'h0) begin n_fail++; $display("FAIL async_rst_b got nonzero ill=%b tv=%b cnt=%0d", b_ill, b_tv, b_cnt); end
    step();
    i_reset = 1'b1;
    drive(32'h00B5_0533, 32'h0000_0600, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    n_tests++; if ({a_vld, a_ill} !== 2'b10 || a_pc !== 32'h600 || a_cnt !== 16'd0) begin n_fail++; $display("FAIL post_rst got=%b %h cnt=%0d exp=10 600 cnt=0", {a_vld, a_ill}, a_pc, a_cnt); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_back_to_back();
    test_system();
    test_stall();
    test_saturate_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
